// File: rtl/async_fifo_gray.sv
// Dual-clock FIFO with Gray-coded pointer crossing, per-domain flags, fill counts and error pulses.
// Define ASYNC_FIFO_FWFT_EN for first-word-fall-through reads; the default build is a registered-read FIFO.
module async_fifo_gray #(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 4,
  parameter int SYNC_STAGES = 2,
  parameter int AF_LEVEL    = 14,
  parameter int AE_LEVEL    = 2
) (
  input  logic                  wr_clk,
  input  logic                  rd_clk,
  input  logic                  rstn,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  full,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   wr_count,
  output logic                  overflow,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  empty,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   rd_count,
  output logic                  underflow
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef logic [ADDR_WIDTH:0] ptr_t;

  localparam ptr_t AF_LVL    = ptr_t'(AF_LEVEL);
  localparam ptr_t AE_LVL    = ptr_t'(AE_LEVEL);
  localparam ptr_t FULL_MASK = ptr_t'(3) << (ADDR_WIDTH - 1);

  function automatic ptr_t bin2gray(input ptr_t b);
    return b ^ (b >> 1);
  endfunction

  function automatic ptr_t gray2bin(input ptr_t g);
    ptr_t b;
    b[ADDR_WIDTH] = g[ADDR_WIDTH];
    for (int i = ADDR_WIDTH - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  ptr_t wr_ptr, wr_gray, wr_ptr_next, wr_gray_next, wr_count_next;
  ptr_t rd_ptr, rd_gray, rd_ptr_next, rd_gray_next, ram_count_next, rd_count_next;
  ptr_t rd_sync [SYNC_STAGES];
  ptr_t wr_sync [SYNC_STAGES];
  ptr_t rd_gray_wq, wr_gray_rq;
  logic wr_inc, rd_inc;
  logic ram_empty, ram_empty_next;

  assign rd_gray_wq = rd_sync[SYNC_STAGES-1];
  assign wr_gray_rq = wr_sync[SYNC_STAGES-1];

  // Write domain: next-state pointer and flag terms
  always_comb begin
    wr_inc        = wr_en & ~full;
    wr_ptr_next   = wr_ptr + ptr_t'(wr_inc);
    wr_gray_next  = bin2gray(wr_ptr_next);
    wr_count_next = wr_ptr_next - gray2bin(rd_gray_wq);
  end

  always_ff @(posedge wr_clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr      <= '0;
      wr_gray     <= '0;
      full        <= 1'b0;
      almost_full <= 1'b0;
      wr_count    <= '0;
      overflow    <= 1'b0;
    end else begin
      wr_ptr      <= wr_ptr_next;
      wr_gray     <= wr_gray_next;
      // Full when the write pointer is exactly one lap ahead of the synced read pointer
      full        <= (wr_gray_next == (rd_gray_wq ^ FULL_MASK));
      almost_full <= (wr_count_next >= AF_LVL);
      wr_count    <= wr_count_next;
      overflow    <= wr_en & full;
    end
  end

  always_ff @(posedge wr_clk) begin
    if (wr_inc) begin
      mem[wr_ptr[ADDR_WIDTH-1:0]] <= wr_data;
    end
  end

  // Read-pointer Gray code into the write domain
  always_ff @(posedge wr_clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < SYNC_STAGES; i++) rd_sync[i] <= '0;
    end else begin
      rd_sync[0] <= rd_gray;
      for (int i = 1; i < SYNC_STAGES; i++) rd_sync[i] <= rd_sync[i-1];
    end
  end

  // Write-pointer Gray code into the read domain
  always_ff @(posedge rd_clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < SYNC_STAGES; i++) wr_sync[i] <= '0;
    end else begin
      wr_sync[0] <= wr_gray;
      for (int i = 1; i < SYNC_STAGES; i++) wr_sync[i] <= wr_sync[i-1];
    end
  end

`ifdef ASYNC_FIFO_FWFT_EN
  logic out_vld, out_vld_next;

  // Prefetch whenever the output word is absent or being acknowledged
  always_comb begin
    rd_inc         = ~ram_empty & (~out_vld | rd_en);
    out_vld_next   = rd_inc | (out_vld & ~rd_en);
    rd_ptr_next    = rd_ptr + ptr_t'(rd_inc);
    rd_gray_next   = bin2gray(rd_ptr_next);
    ram_empty_next = (rd_gray_next == wr_gray_rq);
    ram_count_next = gray2bin(wr_gray_rq) - rd_ptr_next;
    rd_count_next  = ram_count_next + ptr_t'(out_vld_next);
  end

  always_ff @(posedge rd_clk or negedge rstn) begin
    if (!rstn) begin
      out_vld <= 1'b0;
    end else begin
      out_vld <= out_vld_next;
    end
  end

  assign empty = ~out_vld;
`else
  always_comb begin
    rd_inc         = rd_en & ~ram_empty;
    rd_ptr_next    = rd_ptr + ptr_t'(rd_inc);
    rd_gray_next   = bin2gray(rd_ptr_next);
    ram_empty_next = (rd_gray_next == wr_gray_rq);
    ram_count_next = gray2bin(wr_gray_rq) - rd_ptr_next;
    rd_count_next  = ram_count_next;
  end

  assign empty = ram_empty;
`endif

  // Read domain: pointer, flags, and the word leaving storage
  always_ff @(posedge rd_clk or negedge rstn) begin
    if (!rstn) begin
      rd_ptr       <= '0;
      rd_gray      <= '0;
      ram_empty    <= 1'b1;
      almost_empty <= 1'b1;
      rd_count     <= '0;
      underflow    <= 1'b0;
      rd_data      <= '0;
    end else begin
      rd_ptr       <= rd_ptr_next;
      rd_gray      <= rd_gray_next;
      ram_empty    <= ram_empty_next;
      almost_empty <= (rd_count_next <= AE_LVL);
      rd_count     <= rd_count_next;
      underflow    <= rd_en & empty;
      if (rd_inc) begin
        rd_data <= mem[rd_ptr[ADDR_WIDTH-1:0]];
      end
    end
  end

endmodule

// File: tb/tb_async_fifo_gray.sv
// Self-checking bench for async_fifo_gray: directed boundary sequences plus randomized
// dual-clock traffic against a queue-based reference; honours ASYNC_FIFO_FWFT_EN.
`timescale 1ns/100ps
module tb_async_fifo_gray;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int SYNC  = 2;
`ifdef ASYNC_FIFO_FWFT_EN
  localparam int LAT = SYNC + 2;
`else
  localparam int LAT = SYNC + 1;
`endif

  typedef struct {
    logic [DW-1:0] wdata;
    int            cnt;
    bit            af;
    bit            fl;
    bit            ovf;
  } fill_vec_t;

  logic          wr_clk, rd_clk, rstn, wr_en, rd_en;
  logic [DW-1:0] wr_data, rd_data;
  logic          full, almost_full, overflow, empty, almost_empty, underflow;
  logic [AW:0]   wr_count, rd_count;

  real wr_half = 5.0;
  real rd_half = 13.5;
  int  n_checks = 0, n_pass = 0;
  int  ovf_pulses = 0, unf_pulses = 0, rd_edges = 0, snap_rd = 0;
  int  max_wr = 0, max_rd = 0;
  logic [DW-1:0] sb [$];

  async_fifo_gray #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SYNC_STAGES(SYNC), .AF_LEVEL(14), .AE_LEVEL(2)
  ) dut (
    .wr_clk(wr_clk), .rd_clk(rd_clk), .rstn(rstn),
    .wr_en(wr_en), .wr_data(wr_data), .full(full), .almost_full(almost_full),
    .wr_count(wr_count), .overflow(overflow),
    .rd_en(rd_en), .rd_data(rd_data), .empty(empty), .almost_empty(almost_empty),
    .rd_count(rd_count), .underflow(underflow)
  );

  initial begin wr_clk = 1'b0; forever #(wr_half) wr_clk = ~wr_clk; end
  initial begin rd_clk = 1'b0; forever #(rd_half) rd_clk = ~rd_clk; end

  always @(posedge rd_clk) rd_edges++;
  always @(negedge wr_clk) if (overflow === 1'b1) ovf_pulses++;
  always @(negedge rd_clk) if (underflow === 1'b1) unf_pulses++;

  initial begin
    #10ms;
    $display("FAIL watchdog: time limit reached, actual=running required=finished");
    $fatal(1, "bench time limit");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
  endtask

  task automatic write_word(input logic [DW-1:0] d);
    @(posedge wr_clk); #1;
    wr_en = 1'b1; wr_data = d;
    @(posedge wr_clk);
    snap_rd = rd_edges;
    #1 wr_en = 1'b0;
  endtask

  task automatic read_word(output logic [DW-1:0] d);
    int n = 0;
    @(posedge rd_clk); #1;
    while (empty && n < 40) begin @(posedge rd_clk); #1; n++; end
    check("read_ready", 32'(empty), 32'd0);
`ifdef ASYNC_FIFO_FWFT_EN
    d = rd_data;
    rd_en = 1'b1; @(posedge rd_clk); #1; rd_en = 1'b0;
`else
    rd_en = 1'b1; @(posedge rd_clk); #1; rd_en = 1'b0;
    d = rd_data;
`endif
  endtask

  task automatic run_writer(input int total, output int att_full, output bit tmo);
    int sent = 0, cyc = 0, duty = 100, blk = -1;
    logic en;
    logic [DW-1:0] d;
    att_full = 0;
    @(posedge wr_clk); #1;
    while (sent < total && cyc < 30000) begin
      if (sent / DEPTH != blk) begin blk = sent / DEPTH; duty = int'($urandom_range(100, 30)); end
      en = (int'($urandom_range(99, 0)) < duty);
      d  = 8'($urandom);
      wr_en = en; wr_data = d;
      if (en && full) att_full++;
      if (en && !full) begin sb.push_back(d); sent++; end
      if (int'(wr_count) > max_wr) max_wr = int'(wr_count);
      @(posedge wr_clk); #1; cyc++;
    end
    wr_en = 1'b0;
    tmo = (sent < total);
  endtask

  task automatic run_reader(input int total, output int att_empty, output bit tmo);
    int got = 0, cyc = 0, duty = 100, blk = -1;
    logic en, take;
    logic [DW-1:0] exp;
    att_empty = 0;
    @(posedge rd_clk); #1;
    while (got < total && cyc < 30000) begin
      if (got / DEPTH != blk) begin blk = got / DEPTH; duty = int'($urandom_range(100, 30)); end
      en = (int'($urandom_range(99, 0)) < duty);
      rd_en = en;
      take = en && !empty;
      if (en && empty) att_empty++;
      if (int'(rd_count) > max_rd) max_rd = int'(rd_count);
      exp = 'x;
      if (take) begin
        if (sb.size() > 0) exp = sb.pop_front();
        got++;
      end
`ifdef ASYNC_FIFO_FWFT_EN
      if (take) check("rand_data", 32'(rd_data), 32'(exp));
`endif
      @(posedge rd_clk); #1; cyc++;
`ifndef ASYNC_FIFO_FWFT_EN
      if (take) check("rand_data", 32'(rd_data), 32'(exp));
`endif
    end
    rd_en = 1'b0;
    tmo = (got < total);
  endtask

  task automatic run_phase(input real wh, input real rh, input int total);
    int af_att, ae_att, o0, u0;
    bit wto, rto;
    wr_half = wh; rd_half = rh;
    max_wr = 0; max_rd = 0;
    sb.delete();
    repeat (4) @(posedge rd_clk);
    o0 = ovf_pulses; u0 = unf_pulses;
    fork
      run_writer(total, af_att, wto);
      run_reader(total, ae_att, rto);
    join
    repeat (20) @(posedge wr_clk);
    repeat (10) @(posedge rd_clk);
    #1;
    check("rand_writer_done", 32'(wto), 32'd0);
    check("rand_reader_done", 32'(rto), 32'd0);
    check("rand_scoreboard_drained", 32'(sb.size()), 32'd0);
    check("rand_wr_count_le_depth", 32'(max_wr <= DEPTH), 32'd1);
    check("rand_rd_count_le_depth", 32'(max_rd <= DEPTH), 32'd1);
    check("rand_overflow_pulses", 32'(ovf_pulses - o0), 32'(af_att));
    check("rand_underflow_pulses", 32'(unf_pulses - u0), 32'(ae_att));
    check("rand_final_empty", 32'(empty), 32'd1);
    check("rand_final_full", 32'(full), 32'd0);
    check("rand_final_wr_count", 32'(wr_count), 32'd0);
    check("rand_final_rd_count", 32'(rd_count), 32'd0);
  endtask

  initial begin
    fill_vec_t tbl [17];
    logic [DW-1:0] d, d0;
    int n, lat;

    for (int k = 0; k < 17; k++) begin
      tbl[k].wdata = (k < 16) ? 8'(k + 1) : 8'hAA;
      tbl[k].cnt   = (k < 16) ? k + 1 : 16;
      tbl[k].af    = (tbl[k].cnt >= 14);
      tbl[k].fl    = (tbl[k].cnt == 16);
      tbl[k].ovf   = (k == 16);
    end

    wr_en = 1'b0; rd_en = 1'b0; wr_data = '0; rstn = 1'b1;
    #2 rstn = 1'b0;
    #100;
    check("rst_full", 32'(full), 32'd0);
    check("rst_almost_full", 32'(almost_full), 32'd0);
    check("rst_wr_count", 32'(wr_count), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_almost_empty", 32'(almost_empty), 32'd1);
    check("rst_rd_count", 32'(rd_count), 32'd0);
    check("rst_underflow", 32'(underflow), 32'd0);
    check("rst_rd_data", 32'(rd_data), 32'd0);
    @(posedge wr_clk); #1 rstn = 1'b1;
    repeat (3) @(posedge rd_clk);

    // Fill to full with the read side idle, then one more write that must be dropped
    @(posedge wr_clk); #1;
    for (int k = 0; k < 17; k++) begin
      wr_en = 1'b1; wr_data = tbl[k].wdata;
      @(posedge wr_clk); #1;
      check($sformatf("fill%0d_wr_count", k), 32'(wr_count), 32'(tbl[k].cnt));
      check($sformatf("fill%0d_almost_full", k), 32'(almost_full), 32'(tbl[k].af));
      check($sformatf("fill%0d_full", k), 32'(full), 32'(tbl[k].fl));
      check($sformatf("fill%0d_overflow", k), 32'(overflow), 32'(tbl[k].ovf));
    end
    wr_en = 1'b0;
    @(posedge wr_clk); #1;
    check("overflow_one_cycle", 32'(overflow), 32'd0);

    n = 0;
    while (rd_count != 5'd16 && n < 40) begin @(posedge rd_clk); #1; n++; end
    check("rd_count_full", 32'(rd_count), 32'd16);
    check("almost_empty_full", 32'(almost_empty), 32'd0);

    for (int i = 0; i < 16; i++) begin
      read_word(d);
      check($sformatf("drain%0d_data", i), 32'(d), 32'(i + 1));
    end
    check("drain_empty", 32'(empty), 32'd1);
    check("drain_rd_count", 32'(rd_count), 32'd0);
    check("drain_almost_empty", 32'(almost_empty), 32'd1);
    repeat (10) @(posedge wr_clk); #1;
    check("drain_full_clear", 32'(full), 32'd0);
    check("drain_wr_count", 32'(wr_count), 32'd0);
    check("drain_almost_full", 32'(almost_full), 32'd0);
    check("basic_overflow_pulses", 32'(ovf_pulses), 32'd1);
    check("basic_underflow_pulses", 32'(unf_pulses), 32'd0);

    // Read while empty
    @(posedge rd_clk); #1;
    d0 = rd_data;
    rd_en = 1'b1;
    @(posedge rd_clk); #1;
    rd_en = 1'b0;
    check("underflow_pulse", 32'(underflow), 32'd1);
    check("underflow_rd_data_held", 32'(rd_data), 32'(d0));
    @(posedge rd_clk); #1;
    check("underflow_one_cycle", 32'(underflow), 32'd0);
    check("underflow_pulse_count", 32'(unf_pulses), 32'd1);

    // Single write crossing into the read domain
    write_word(8'h5C);
    n = 0;
    while (empty && n < 40) begin @(posedge rd_clk); #1; n++; end
    lat = rd_edges - snap_rd;
    check("empty_latency", 32'(lat), 32'(LAT));
    check("single_rd_count", 32'(rd_count), 32'd1);
    read_word(d);
    check("single_data", 32'(d), 32'h5C);
    check("single_empty_after", 32'(empty), 32'd1);

`ifdef ASYNC_FIFO_FWFT_EN
    write_word(8'h3E);
    n = 0;
    while (empty && n < 40) begin @(posedge rd_clk); #1; n++; end
    check("fwft_rd_data", 32'(rd_data), 32'h3E);
    check("fwft_not_empty", 32'(empty), 32'd0);
    @(posedge rd_clk); #1;
    rd_en = 1'b1;
    @(posedge rd_clk); #1;
    rd_en = 1'b0;
    check("fwft_empty_after_ack", 32'(empty), 32'd1);
`endif

    // Reset with data queued
    for (int i = 0; i < 9; i++) write_word(8'(8'h40 + i));
    repeat (8) @(posedge rd_clk);
    @(posedge wr_clk); #1;
    rstn = 1'b0;
    repeat (2) @(posedge wr_clk);
    #1;
    check("midrst_empty", 32'(empty), 32'd1);
    check("midrst_full", 32'(full), 32'd0);
    check("midrst_rd_count", 32'(rd_count), 32'd0);
    check("midrst_wr_count", 32'(wr_count), 32'd0);
    check("midrst_rd_data", 32'(rd_data), 32'd0);
    rstn = 1'b1;
    write_word(8'h77);
    read_word(d);
    check("midrst_first_data", 32'(d), 32'h77);
    check("midrst_empty_after", 32'(empty), 32'd1);

    run_phase(5.0, 15.0, 800);
    run_phase(15.0, 5.0, 800);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/async_fifo_gray.md
Name: async_fifo_gray

Overview:
- Parametrised dual-clock FIFO; next generation of the team's 8x16 asynchronous FIFO.
- Adds:
  - independent write-side and read-side pointers
  - Gray-coded pointer crossing through multi-flop synchronisers
  - per-domain status flags and fill counts
  - programmable almost-full and almost-empty thresholds
  - overflow and underflow error pulses
- Sits between a producer on wr_clk and a consumer on rd_clk, e.g. a sample stream entering a slower processing domain.

Parameters:
- DATA_WIDTH, 8: word width in bits.
- ADDR_WIDTH, 4: address bits. DEPTH = 2**ADDR_WIDTH, so 16 entries by default.
- SYNC_STAGES, 2: synchroniser flops per crossing. Legal values are 2 to 4.
- AF_LEVEL, 14: almost_full asserts when wr_count >= AF_LEVEL.
- AE_LEVEL, 2: almost_empty asserts when rd_count <= AE_LEVEL.

Ports:
- wr_clk, in, 1: write clock.
- rd_clk, in, 1: read clock, asynchronous to wr_clk.
- rstn, in, 1: reset, asynchronous, active-low. Clears both domains.
- wr_en, in, 1: write request.
- wr_data, in, DATA_WIDTH: write word.
- full, out, 1: FIFO full, wr_clk domain.
- almost_full, out, 1: threshold flag, wr_clk domain.
- wr_count, out, ADDR_WIDTH+1: fill level as seen by the write side.
- overflow, out, 1: one-cycle pulse on a write attempt while full.
- rd_en, in, 1: read request.
- rd_data, out, DATA_WIDTH: read word.
- empty, out, 1: FIFO empty, rd_clk domain.
- almost_empty, out, 1: threshold flag, rd_clk domain.
- rd_count, out, ADDR_WIDTH+1: fill level as seen by the read side.
- underflow, out, 1: one-cycle pulse on a read attempt while empty.

Behaviour:
- Pointers
  - wr_ptr and rd_ptr are ADDR_WIDTH+1 bits wide, binary, with registered Gray copies.
  - Each pointer is owned solely by its own clock domain.
  - Each Gray pointer crosses into the other domain through SYNC_STAGES flops. No binary pointer crosses domains.
- Write
  - On the wr_clk edge with wr_en=1 and full=0: mem[wr_ptr[ADDR_WIDTH-1:0]] <= wr_data, and wr_ptr increments.
  - With wr_en=1 and full=1: the write is dropped and overflow=1 for that cycle.
- Read
  - On the rd_clk edge with rd_en=1 and empty=0: rd_data <= head word (latency 1 rd_clk), and rd_ptr increments.
  - With rd_en=1 and empty=1: rd_data holds its value and underflow=1 for that cycle.
- Flags
  - All flags are registered in their own domain.
  - full = (next wr Gray) == (synced rd Gray with its two MSBs inverted).
  - empty = (next rd Gray) == (synced wr Gray).
- Counts
  - wr_count = wr_ptr - bin(synced rd Gray), modulo 2**(ADDR_WIDTH+1).
  - rd_count = bin(synced wr Gray) - rd_ptr, same modulo.
  - Both counts are registered, range 0..DEPTH.
- Conservatism
  - Write-side flags and counts may overstate the fill level; read-side ones may understate it.
  - Neither side may ever permit an overflow or underflow of the storage.
- Crossing latency
  - A write becomes visible to the read side (empty deasserts) SYNC_STAGES+1 rd_clk edges after the writing wr_clk edge.
  - A read frees space on the write side (full deasserts) SYNC_STAGES+1 wr_clk edges after the reading rd_clk edge.
- Wrap-around: the pointer MSB toggles every DEPTH operations. Flags stay correct across an unlimited number of wraps.
- Simultaneous write and read while neither full nor empty: both operations proceed and the fill level is unchanged.
- Reset values (rstn low), applied asynchronously to both domains:
  - pointers, Gray copies and synchronisers = 0
  - full=0, almost_full=0, wr_count=0, overflow=0
  - empty=1, almost_empty=1, rd_count=0, underflow=0
  - rd_data=0
- Storage is not reset; its contents are undefined after reset.
- Reset mid-operation:
  - all queued data is discarded
  - the first write after reset deassertion lands at address 0
  - both sides see the FIFO as empty
- Parameter rules: AF_LEVEL must be in 1..DEPTH and AE_LEVEL in 0..DEPTH-1; out-of-range values are illegal.

Optional Feature:
- Macro: ASYNC_FIFO_FWFT_EN
- Defined: first-word-fall-through mode.
  - The head word is prefetched into rd_data with no rd_en.
  - empty=0 means rd_data is valid now; rd_en acts as an acknowledge that pops the word and loads the next one.
  - rd_count includes the prefetched word.
  - A write reaches rd_data SYNC_STAGES+2 rd_clk edges after the writing wr_clk edge.
- Undefined: standard mode as above, with rd_data valid 1 rd_clk after a rd_en accepted while not empty.

Test Plan:
- Basic ordering: defaults, wr_clk 100 MHz, rd_clk 37 MHz. Write 0x01..0x10, then read all 16 -> rd_data sequence 0x01..0x10; empty=1 after the 16th read; no overflow or underflow pulses.
- Full boundary: write 16 words with the read side idle -> full=1 after the 16th write edge; almost_full=1 once wr_count reaches 14; a 17th write with 0xAA -> overflow pulses for 1 cycle and 0xAA is never read out.
- Empty boundary: read with the FIFO empty -> underflow pulses and rd_data is unchanged. Write one word 0x5C -> empty=0 exactly 3 rd_clk edges later; next rd_en -> rd_data=0x5C.
- Wrap-around: 100 full fill/drain cycles with random data and random en duty at clock ratios 1:3 and 3:1 -> scoreboard matches, and wr_count / rd_count never exceed 16.
- Reset mid-operation: 9 words queued, assert rstn low for 2 cycles -> empty=1, full=0, rd_count=0, rd_data=0. Then write 0x77 and read -> rd_data=0x77.
- FWFT (macro defined): write 0x3E with rd_en held 0 -> rd_data=0x3E and empty=0 without any rd_en; one rd_en pulse -> empty=1.
